sa_raddr_channel: RTL and testbench

Slave-arbitration read-address channel of the AXI4 interconnect: arbitrates AR requests from all master dispatchers toward one slave port. Splits INCR bursts that cross a 4 KB boundary into two slave transactions. Pushes per-transaction ordering info (slave ID + crossing flag) to the read-data channel so it can suppress the first half's RLAST. Sits beside the slave-arbitration RDATA channel, one instance per slave port.

---
 rtl/sa_raddr_channel.sv | 130 +++++++++++++
 tb/tb_sa_raddr_channel.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_raddr_channel.sv
// sa_raddr_channel: slave-side AR arbiter with 4 KB INCR burst splitting and RDATA ordering push.
// Build option: SA_RADDR_BOUNDARY_SPLIT_EN enables 4 KB boundary splitting; without it every request is issued verbatim.
// Ports:
//   ACLK_i, ARESETn_i          clock, asynchronous active-low reset
//   dsp_AR*_i / dsp_ARREADY_o  per-master AR requests (flattened, master 0 in the low slice) and one-hot grant
//   m_AR*_o / m_ARREADY_i      slave AR channel, m_ARID_o = {master index, ARID}
//   R_AxID_o, R_crossing_flag_o, R_shift_en_o  ordering entry pushed to the RDATA filter on each slave handshake
//   R_stall_i                  RDATA filter FIFO full; blocks new grants and the second half of a split
module sa_raddr_channel #(
  parameter int MST_AMT           = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 8,
  parameter int TRANS_DATA_SIZE_W = 3
) (
  input  logic                                    ACLK_i,
  input  logic                                    ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]       dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]           dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]        dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]     dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]    dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                      dsp_ARVALID_i,
  output logic [MST_AMT-1:0]                      dsp_ARREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]               m_ARID_o,
  output logic [ADDR_WIDTH-1:0]                   m_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]                m_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]             m_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]            m_ARSIZE_o,
  output logic                                    m_ARVALID_o,
  input  logic                                    m_ARREADY_i,
  output logic [TRANS_SLV_ID_W-1:0]               R_AxID_o,
  output logic                                    R_crossing_flag_o,
  output logic                                    R_shift_en_o,
  input  logic                                    R_stall_i
);
  localparam int HI_W = ADDR_WIDTH - 12;
  typedef enum logic [1:0] {IDLE, ISSUE, ISSUE2} state_t;
  state_t r_state, w_next;
  logic [TRANS_MST_ID_W-1:0]    w_id_a    [MST_AMT];
  logic [ADDR_WIDTH-1:0]        w_addr_a  [MST_AMT];
  logic [TRANS_BURST_W-1:0]     w_burst_a [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  w_len_a   [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] w_size_a  [MST_AMT];
  logic [MST_ID_W-1:0]          r_ptr, w_win, w_idx;
  logic                         w_grant, w_hs, w_cross, r_valid, r_cross;
  logic [TRANS_SLV_ID_W-1:0]    r_id;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [TRANS_BURST_W-1:0]     r_burst;
  logic [TRANS_DATA_LEN_W-1:0]  r_len, w_len1;
  logic [TRANS_DATA_SIZE_W-1:0] r_size;
  logic [12:0]                  w_rem;
  for (genvar m = 0; m < MST_AMT; m++) begin : g_unpack
    assign w_id_a[m]    = dsp_ARID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign w_addr_a[m]  = dsp_ARADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_burst_a[m] = dsp_ARBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W];
    assign w_len_a[m]   = dsp_ARLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign w_size_a[m]  = dsp_ARSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  end
  // Scan from the farthest offset down so the requester closest to the pointer wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      w_idx = MST_ID_W'((int'(r_ptr) + i) % MST_AMT);
      if (dsp_ARVALID_i[w_idx]) w_win = w_idx;
    end
  end
  assign w_grant       = r_state == IDLE && |dsp_ARVALID_i && !R_stall_i;
  assign dsp_ARREADY_o = w_grant ? MST_AMT'(1) << w_win : '0;
  assign w_hs          = r_valid & m_ARREADY_i;
`ifdef SA_RADDR_BOUNDARY_SPLIT_EN
  logic [16:0] w_bytes;
  assign w_bytes = (17'(w_len_a[w_win]) + 17'd1) << w_size_a[w_win];
  assign w_cross = w_burst_a[w_win] == 2'b01 && 17'(w_addr_a[w_win][11:0]) + w_bytes > 17'd4096;
`else
  assign w_cross = 1'b0;
`endif
  // First half covers the bytes up to the 4 KB page end; second half the remainder.
  assign w_rem             = 13'd4096 - 13'(r_addr[11:0]);
  assign w_len1            = TRANS_DATA_LEN_W'((w_rem >> r_size) - 13'd1);
  assign m_ARVALID_o       = r_valid;
  assign m_ARID_o          = r_id;
  assign m_ARBURST_o       = r_burst;
  assign m_ARSIZE_o        = r_size;
  assign m_ARADDR_o        = r_state == ISSUE2 ? {r_addr[ADDR_WIDTH-1:12] + HI_W'(1), 12'h000} : r_addr;
  assign m_ARLEN_o         = r_state == ISSUE2 ? r_len - w_len1 - TRANS_DATA_LEN_W'(1) : r_cross ? w_len1 : r_len;
  assign R_shift_en_o      = w_hs;
  assign R_AxID_o          = r_id;
  assign R_crossing_flag_o = w_hs & r_cross & (r_state == ISSUE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant ? ISSUE : IDLE;
      ISSUE:   w_next = w_hs ? (r_cross ? ISSUE2 : IDLE) : ISSUE;
      ISSUE2:  w_next = w_hs ? IDLE : ISSUE2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge ACLK_i or negedge ARESETn_i)
    if (!ARESETn_i) r_state <= IDLE;
    else r_state <= w_next;
  // Valid is set at grant; after the first half of a split it re-arms only once the RDATA FIFO has room.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_cross <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_burst <= '0;
      r_len   <= '0;
      r_size  <= '0;
    end else begin
      r_valid <= w_grant | (~w_hs & (r_valid | (r_state != IDLE & ~R_stall_i)));
      if (w_grant) begin
        r_ptr   <= w_win == MST_ID_W'(MST_AMT - 1) ? '0 : w_win + MST_ID_W'(1);
        r_cross <= w_cross;
        r_id    <= {w_win, w_id_a[w_win]};
        r_addr  <= w_addr_a[w_win];
        r_burst <= w_burst_a[w_win];
        r_len   <= w_len_a[w_win];
        r_size  <= w_size_a[w_win];
      end
    end
  end
endmodule

// File: tb/tb_sa_raddr_channel.sv
// tb_sa_raddr_channel: scoreboard bench for the slave AR arbiter/splitter.
module tb_sa_raddr_channel;
  localparam int M = 3, AW = 32, IW = 5, SW = 7;
  typedef struct packed {
    logic sh; logic fl; logic [SW-1:0] rid; logic [SW-1:0] id; logic [AW-1:0] addr; logic [7:0] len;
  } txn_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [IW*M-1:0] arid;
  logic [AW*M-1:0] araddr;
  logic [2*M-1:0] arburst;
  logic [8*M-1:0] arlen;
  logic [3*M-1:0] arsize;
  logic [M-1:0] arvalid, arready;
  logic [SW-1:0] m_id, r_id;
  logic [AW-1:0] m_addr;
  logic [1:0] m_burst;
  logic [7:0] m_len;
  logic [2:0] m_size;
  logic m_valid, m_ready, r_flag, r_shift, r_stall;
  txn_t exp_q[$], obs_q[$];
  int gnt_q[$];
  bit two_hot;
  int checks, passed;
  sa_raddr_channel dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .dsp_ARID_i(arid), .dsp_ARADDR_i(araddr), .dsp_ARBURST_i(arburst), .dsp_ARLEN_i(arlen),
    .dsp_ARSIZE_i(arsize), .dsp_ARVALID_i(arvalid), .dsp_ARREADY_o(arready),
    .m_ARID_o(m_id), .m_ARADDR_o(m_addr), .m_ARBURST_o(m_burst), .m_ARLEN_o(m_len),
    .m_ARSIZE_o(m_size), .m_ARVALID_o(m_valid), .m_ARREADY_i(m_ready),
    .R_AxID_o(r_id), .R_crossing_flag_o(r_flag), .R_shift_en_o(r_shift), .R_stall_i(r_stall)
  );
  always @(negedge clk) begin
    if (m_valid && m_ready) obs_q.push_back({r_shift, r_flag, r_id, m_id, m_addr, m_len});
    if (arready != 0) gnt_q.push_back($clog2(arready));
    if ($countones(arready) > 1) two_hot = 1'b1;
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic txn_t mk(input logic fl, input int m, input int id, input logic [AW-1:0] a, input logic [7:0] l);
    logic [SW-1:0] i;
    i = {2'(m), 5'(id)};
    return {1'b1, fl, i, i, a, l};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int m, input int id, input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s);
    arid[m*IW +: IW] = 5'(id);
    araddr[m*AW +: AW] = a;
    arburst[m*2 +: 2] = 2'b01;
    arlen[m*8 +: 8] = l;
    arsize[m*3 +: 3] = s;
  endtask
  task automatic send(input int m, input int id, input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, output bit got);
    set_req(m, id, a, l, s);
    arvalid[m] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = arready[m];
    end
    @(posedge clk);
    #1;
    arvalid[m] = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; arvalid = '0; arid = '0; araddr = '0; arburst = '0; arlen = '0; arsize = '0;
    m_ready = 1'b1; r_stall = 1'b0;
    cyc(3);
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_valid); else passed++;
    checks++; if (arready !== '0) $display("FAIL reset_arready got %b want 000", arready); else passed++;
    checks++; if ({r_shift, r_flag, r_id} !== '0) $display("FAIL reset_push got %b want 0", {r_shift, r_flag, r_id}); else passed++;
    checks++; if ({m_id, m_addr, m_len} !== '0) $display("FAIL reset_fields got %h want 0", {m_id, m_addr, m_len}); else passed++;
    rst_n = 1'b1;
  endtask
  task automatic test_round_robin;
    txn_t e, o;
    gnt_q.delete(); two_hot = 1'b0;
    set_req(0, 1, 32'h200, 8'd0, 3'd2);
    set_req(2, 2, 32'h300, 8'd0, 3'd2);
    arvalid = 3'b101;
    for (int i = 0; i < 40 && gnt_q.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    arvalid = '0;
    for (int k = 0; k < 4; k++) exp_q.push_back(k % 2 ? mk(0, 2, 2, 32'h300, 0) : mk(0, 0, 1, 32'h200, 0));
    cyc(4);
    checks++; if (gnt_q.size() !== 4) $display("FAIL rr_grant_count got %0d want 4", gnt_q.size()); else passed++;
    for (int k = 0; k < 4 && k < gnt_q.size(); k++) begin
      checks++; if (gnt_q[k] !== (k % 2 ? 2 : 0)) $display("FAIL rr_grant%0d got %0d want %0d", k, gnt_q[k], k % 2 ? 2 : 0); else passed++;
    end
    checks++; if (two_hot !== 1'b0) $display("FAIL rr_onehot got two-hot want one-hot"); else passed++;
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rr_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() && obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL rr_txn got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_single;
    txn_t e, o;
    bit got;
    exp_q.push_back(mk(0, 1, 5, 32'h100, 8'd3));
    send(1, 5, 32'h100, 8'd3, 3'd2, got);
    checks++; if (!got) $display("FAIL single_grant got no ARREADY[1] want pulse"); else passed++;
    checks++; if (m_valid !== 1'b1) $display("FAIL single_latency got valid %b want 1", m_valid); else passed++;
    cyc(4);
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() && obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL single_txn got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_split;
    txn_t e, o;
    bit got;
`ifdef SA_RADDR_BOUNDARY_SPLIT_EN
    exp_q.push_back(mk(1, 0, 9, 32'hFF0, 8'd3));
    exp_q.push_back(mk(0, 0, 9, 32'h1000, 8'd3));
`else
    exp_q.push_back(mk(0, 0, 9, 32'hFF0, 8'd7));
`endif
    send(0, 9, 32'hFF0, 8'd7, 3'd2, got);
    checks++; if (!got) $display("FAIL split_grant got no ARREADY[0] want pulse"); else passed++;
    cyc(6);
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL split_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() && obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL split_txn got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_stall;
    txn_t e, o;
    bit got, bad;
    int n0;
    r_stall = 1'b1;
    set_req(1, 4, 32'h500, 8'd0, 3'd2);
    arvalid[1] = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (arready !== '0 || m_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL stall_block got grant/valid want none"); else passed++;
    @(posedge clk); #1;
    r_stall = 1'b0;
    @(negedge clk);
    checks++; if (arready !== 3'b010) $display("FAIL stall_release got %b want 010", arready); else passed++;
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    exp_q.push_back(mk(0, 1, 4, 32'h500, 8'd0));
    cyc(4);
`ifdef SA_RADDR_BOUNDARY_SPLIT_EN
    exp_q.push_back(mk(1, 0, 6, 32'hFF0, 8'd3));
    exp_q.push_back(mk(0, 0, 6, 32'h1000, 8'd3));
`else
    exp_q.push_back(mk(0, 0, 6, 32'hFF0, 8'd7));
`endif
    n0 = obs_q.size();
    send(0, 6, 32'hFF0, 8'd7, 3'd2, got);
    checks++; if (!got) $display("FAIL stall_split_grant got no ARREADY[0] want pulse"); else passed++;
    for (int i = 0; i < 10 && obs_q.size() == n0; i++) @(negedge clk);
    @(posedge clk); #1;
    r_stall = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL stall_issue2 got valid high want low while stalled"); else passed++;
    @(posedge clk); #1;
    r_stall = 1'b0;
    cyc(4);
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() && obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL stall_txn got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_backpressure;
    txn_t e, o;
    bit got, bad;
    m_ready = 1'b0;
    exp_q.push_back(mk(0, 2, 3, 32'h2000, 8'd15));
    send(2, 3, 32'h2000, 8'd15, 3'd3, got);
    checks++; if (!got) $display("FAIL bp_grant got no ARREADY[2] want pulse"); else passed++;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_addr !== 32'h2000 || m_len !== 8'd15 || m_id !== {2'd2, 5'd3} ||
          m_size !== 3'd3 || m_burst !== 2'b01 || r_shift !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL bp_hold got valid=%b addr=%h len=%0d shift=%b want held request", m_valid, m_addr, m_len, r_shift); else passed++;
    @(posedge clk); #1;
    m_ready = 1'b1;
    cyc(3);
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() && obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL bp_txn got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_reset_mid;
    txn_t e, o;
    bit got;
    int n0;
`ifdef SA_RADDR_BOUNDARY_SPLIT_EN
    exp_q.push_back(mk(1, 1, 7, 32'hFFC, 8'd0));
`else
    exp_q.push_back(mk(0, 1, 7, 32'hFFC, 8'd1));
`endif
    n0 = obs_q.size();
    send(1, 7, 32'hFFC, 8'd1, 3'd2, got);
    checks++; if (!got) $display("FAIL rmid_grant got no ARREADY[1] want pulse"); else passed++;
    for (int i = 0; i < 10 && obs_q.size() == n0; i++) @(negedge clk);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(posedge clk); #1;
`ifdef SA_RADDR_BOUNDARY_SPLIT_EN
    checks++; if (m_valid !== 1'b1 || m_addr !== 32'h1000) $display("FAIL rmid_issue2 got valid=%b addr=%h want 1 00001000", m_valid, m_addr); else passed++;
`endif
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", m_valid); else passed++;
    checks++; if ({arready, r_shift, r_flag} !== '0) $display("FAIL rmid_ready got %b want 0", {arready, r_shift, r_flag}); else passed++;
    checks++; if ({m_id, m_addr, m_len} !== '0) $display("FAIL rmid_fields got %h want 0", {m_id, m_addr, m_len}); else passed++;
    cyc(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    set_req(0, 2, 32'h40, 8'd0, 3'd2);
    set_req(2, 3, 32'h80, 8'd0, 3'd2);
    arvalid = 3'b101;
    @(negedge clk);
    checks++; if (arready !== 3'b001) $display("FAIL rmid_first_grant got %b want 001", arready); else passed++;
    @(posedge clk); #1;
    arvalid = '0;
    exp_q.push_back(mk(0, 0, 2, 32'h40, 8'd0));
    cyc(4);
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rmid_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() && obs_q.size()) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL rmid_txn got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
  initial begin
    checks = 0; passed = 0;
    test_reset;
    test_round_robin;
    test_single;
    test_split;
    test_stall;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
